// File: rtl/fetch_queue.sv
// fetch_queue: issues PC-stage fetch addresses to a req/ack instruction memory and buffers
// returned {pc, instr} pairs toward decode. Define FETCH_STATS_EN to add the stall_cycles counter.
module fetch_queue #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    input  logic                   pc_valid,
    output logic                   pc_ready,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    input  logic                   flush,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];
    logic [INSTR_WIDTH-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;

    logic accept;
    logic push;
    logic pop;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake outputs and queue strobes
    always_comb begin
        state_nxt = state;
        pc_ready  = 1'b0;
        mem_req   = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;

        pop = (count != '0) && instr_ready && !flush;

        case (state)
            IDLE: begin
                pc_ready = (count < FULL_CNT) && !flush;
                accept   = pc_valid && pc_ready;
                if (accept) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    // An ack coinciding with flush belongs to the squashed path.
                    push      = !flush;
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                // Memory cannot abort; keep requesting until the stale ack drains.
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request address, held for the whole req/ack handshake
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
        end else if (accept) begin
            mem_addr <= pc_in;
        end
    end

    // Queue pointers and occupancy; flush wins over push and pop
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage, cleared on reset so the head never reads X
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= mem_addr;
            data_mem[wr_ptr] <= mem_rdata;
        end
    end

    assign instr_valid = (count != '0);
    assign instr_out   = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

`ifdef FETCH_STATS_EN
    // Saturating count of cycles the PC stage was held off
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (pc_valid && !pc_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    // A push can only follow an accept taken with room, so overflow is impossible
    assert property (@(posedge clock) disable iff (reset) push |-> (count < FULL_CNT));
    assert property (@(posedge clock) disable iff (reset) (mem_req && !mem_ack) |=> $stable(mem_addr));

endmodule
